// File: rtl/draw_window_if.sv
// Frame-source read bus: shared linear address, per-source enables and the
// concatenated read data returned by all sources.
interface draw_window_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned PIX_W  = 24,
    parameter int unsigned NSRC   = 2
) ();
    logic [ADDR_W-1:0]     rd_addr;
    logic [NSRC-1:0]       rd_en;
    logic [NSRC*PIX_W-1:0] rd_data;

    modport master (output rd_addr, output rd_en, input  rd_data);
    modport slave  (input  rd_addr, input  rd_en, output rd_data);
endinterface

// File: rtl/draw_window.sv
// Places a WIDTH x HEIGHT picture window in the raster, reads it from one of NSRC
// frame sources and presents latency-aligned pixels on a DDR DVI bus.
module draw_window #(
    parameter int unsigned H_START = 78,
    parameter int unsigned V_START = 105,
    parameter int unsigned WIDTH   = 480,
    parameter int unsigned HEIGHT  = 270,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned PIX_W   = 24,
    parameter int unsigned NSRC    = 2,
    parameter int unsigned SRC_W   = 1,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         xpos,
    input  logic [9:0]         ypos,
    input  logic               vsync,
    input  logic [SRC_W-1:0]   src_sel,
    input  logic               pic_done,
    draw_window_if.master      rd,
    output logic [SRC_W-1:0]   active_src,
    output logic               valid,
    output logic               pix_valid,
    output logic [PIX_W-1:0]   pix_data,
    output logic [PIX_W/2-1:0] dvi_d,
    output logic               frame_done
);
    localparam int unsigned       NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [10:0]       X_LO      = 11'(H_START);
    localparam logic [10:0]       X_HI      = 11'(H_START + WIDTH);
    localparam logic [10:0]       Y_LO      = 11'(V_START);
    localparam logic [10:0]       Y_HI      = 11'(V_START + HEIGHT);

    typedef enum logic [1:0] {IDLE, ARM, SHOW} state_e;

    state_e            state_q;
    logic              vsync_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SRC_W-1:0]  src_q, src_d, src_tap;
    logic              win, vs_rise, show_now, last_now, show_win;
    logic [RD_LAT:1]   win_p, show_p, last_p;
    logic [RD_LAT:0]   win_s, show_s, last_s;
    logic [PIX_W-1:0]  slice, data_q;

    always_comb begin
        win = ({1'b0, xpos} >= X_LO) && ({1'b0, xpos} < X_HI) &&
              ({1'b0, ypos} >= Y_LO) && ({1'b0, ypos} < Y_HI);
    end

    assign valid    = win;
    assign vs_rise  = vsync && !vsync_q;
    assign show_now = (state_q == SHOW);
    assign last_now = (addr_q == LAST_ADDR);
    assign show_win = show_now && win;

    always_comb begin
        src_d = src_q;
        if (vs_rise && (32'(src_sel) < 32'(NSRC)))
            src_d = src_sel;
        addr_d = addr_q;
        if (vs_rise || (xpos == '0 && ypos == '0) || ({1'b0, ypos} >= Y_HI))
            addr_d = '0;
        else if (win && !last_now)
            addr_d = addr_q + ADDR_W'(1);
    end

    assign rd.rd_addr = show_win ? addr_q : '0;
    assign rd.rd_en   = show_win ? (NSRC'(1) << src_q) : '0;

    // Bit 0 of each *_s vector is the live value; bit i is the value i cycles old.
    assign win_s  = {win_p, win};
    assign show_s = {show_p, show_now};
    assign last_s = {last_p, last_now};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            state_q <= IDLE;
            src_q   <= '0;
            addr_q  <= '0;
            win_p   <= '0;
            show_p  <= '0;
            last_p  <= '0;
            data_q  <= '0;
        end else begin
            vsync_q <= vsync;
            src_q   <= src_d;
            addr_q  <= addr_d;
            win_p   <= win_s[RD_LAT-1:0];
            show_p  <= show_s[RD_LAT-1:0];
            last_p  <= last_s[RD_LAT-1:0];
            data_q  <= (win_s[RD_LAT-1] && show_s[RD_LAT-1]) ? slice : '0;
            case (state_q)
                IDLE:    if (pic_done) state_q <= ARM;
                ARM:     if (!pic_done) state_q <= IDLE;
                         else if (vs_rise) state_q <= SHOW;
                SHOW:    if (!pic_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The output register is the last latency stage, so the source tag is
    // carried RD_LAT-1 cycles to meet the returning data.
    if (RD_LAT == 1) begin : g_src_direct
        assign src_tap = src_q;
    end else begin : g_src_pipe
        logic [SRC_W-1:0] src_p [RD_LAT-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < RD_LAT - 1; i++) src_p[i] <= '0;
            end else begin
                src_p[0] <= src_q;
                for (int unsigned i = 1; i < RD_LAT - 1; i++) src_p[i] <= src_p[i-1];
            end
        end
        assign src_tap = src_p[RD_LAT-2];
    end

    always_comb begin
        slice = '0;
        for (int unsigned s = 0; s < NSRC; s++)
            if (src_tap == SRC_W'(s)) slice = rd.rd_data[s*PIX_W +: PIX_W];
    end

    assign active_src = src_q;
    assign pix_valid  = win_p[RD_LAT];
    assign pix_data   = data_q;
    assign frame_done = win_p[RD_LAT] && show_p[RD_LAT] && last_p[RD_LAT];
    assign dvi_d      = clk ? pix_data[PIX_W-1:PIX_W/2] : pix_data[PIX_W/2-1:0];
endmodule

// File: doc/draw_window.md
# draw_window

Parametrised display-window reader for the VGA/DVI output path. It places a WIDTH×HEIGHT picture window at (H_START, V_START) in the raster. It generates linear read addresses into NSRC frame sources (ROM/RAM picture buffers) and switches the active source only on a vsync rising edge. It waits for a frame boundary before showing a newly finished picture, aligns returned pixels to a configurable read latency, and drives the 12-bit DDR DVI bus.

## Interface
Parameters:
- H_START, 78, first active column (xpos)
- V_START, 105, first active row (ypos)
- WIDTH, 480, window width in pixels
- HEIGHT, 270, window height in lines
- ADDR_W, 17, read address width; WIDTH*HEIGHT ≤ 2^ADDR_W
- PIX_W, 24, pixel width; must be even
- NSRC, 2, number of frame sources (≥1)
- SRC_W, 1, width of source select; 2^SRC_W ≥ NSRC
- RD_LAT, 2, cycles from rd_addr to valid rd_data slice (≥1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- xpos  in  10  raster column
- ypos  in  10  raster row
- vsync  in  1  vertical sync, rising edge = frame boundary
- src_sel  in  SRC_W  requested source
- pic_done  in  1  picture buffers hold a complete image
- rd_data  in  NSRC*PIX_W  source s occupies bits [s*PIX_W +: PIX_W]
- rd_addr  out  ADDR_W  linear pixel address, shared by all sources
- rd_en  out  NSRC  one-hot read enable of active source
- active_src  out  SRC_W  source in use this frame
- valid  out  1  raster inside window (combinational)
- pix_valid  out  1  valid delayed RD_LAT cycles
- pix_data  out  PIX_W  aligned pixel, 0 when not shown
- dvi_d  out  PIX_W/2  DDR output: upper half while clk=1, lower half while clk=0
- frame_done  out  1  one-cycle pulse on last window pixel out

## Operation
- win = H_START ≤ xpos < H_START+WIDTH && V_START ≤ ypos < V_START+HEIGHT; valid = win.
- vs_rise = vsync && !vsync_r, where vsync_r is a registered vsync that resets to 0.
- Source latch: on vs_rise, active_src ← src_sel if src_sel < NSRC; otherwise it holds. Never changes mid-frame.
- Show-state FSM (reset IDLE):
  - IDLE → ARM when pic_done=1.
  - ARM → SHOW on vs_rise while pic_done=1.
  - ARM or SHOW → IDLE whenever pic_done=0. This takes priority, in the same cycle.
- addr_cnt (ADDR_W bits):
  - cleared on vs_rise, at xpos=0&&ypos=0, and when ypos ≥ V_START+HEIGHT.
  - else +1 each cycle win=1.
  - holds outside the window columns.
  - During the k-th window pixel of a frame, addr_cnt = k (0 … WIDTH*HEIGHT-1). It saturates at WIDTH*HEIGHT-1 and never wraps.
- rd_addr = addr_cnt when state=SHOW && win, else 0.
- rd_en = one-hot(active_src) under the same condition, else 0.
- Pipeline of RD_LAT stages carries win, show (state=SHOW), src and the last-pixel flag (addr_cnt = WIDTH*HEIGHT-1). pix_valid = win delayed RD_LAT.
- pix_data = rd_data slice of the delayed src when the delayed win and show are both 1, else 0. The value is registered.
- dvi_d = pix_data[PIX_W-1:PIX_W/2] when clk=1, pix_data[PIX_W/2-1:0] when clk=0.
- frame_done = delayed last-pixel flag && delayed win && delayed show.

## Timing
- Reset: vsync_r=0, state=IDLE, active_src=0, addr_cnt=0, all pipeline stages 0.
  - Outputs: rd_addr=0, rd_en=0, pix_valid=0, pix_data=0, dvi_d=0, frame_done=0.
  - valid follows xpos/ypos even in reset.
- Address-to-pixel latency is exactly RD_LAT cycles. The pixel for rd_addr=k appears on pix_data RD_LAT cycles after rd_addr=k.
- A source or pic_done change affects the first pixel of the next frame only. The exception is pic_done falling, which blanks output RD_LAT cycles later.
- Simultaneous events:
  - vs_rise and pic_done rising in the same cycle: FSM goes IDLE→ARM; SHOW waits for the next vs_rise.
  - vs_rise with an invalid src_sel: active_src holds.
- Reset asserted mid-frame: all state clears immediately. After release, the FSM needs pic_done plus a fresh vs_rise before showing.

## Test plan
- Default params, pic_done=1 before the first vsync, src_sel=0, ROM model returns data=address: after the second frame edge, pix_data for row 0 col 0 = 0x000000 at 2 cycles after (x=78,y=105); the last pixel = 129599 (0x01FA3F) with frame_done pulsing once.
- src_sel toggles 0→1 mid-frame: active_src and rd_en stay 0b01 until the next vs_rise, then become 1 and 0b10. No mixed-source pixels within a frame.
- pic_done rises mid-frame: no output until one full vs_rise→SHOW transition. pic_done drops at window pixel 1000: pix_data becomes 0 from 2 cycles later and rd_en=0 immediately.
- Sweep RD_LAT=1 and 4 with NSRC=3, src_sel=3: src_sel is ignored, and pix_valid lags valid by exactly RD_LAT.
- rst_n pulses low mid-window: all outputs are 0 within the same cycle. Recovery requires pic_done=1 and a vs_rise, and rd_addr restarts at 0.
- Pixel 0xABCDEF shown: dvi_d = 0xABC while clk=1 and 0xDEF while clk=0. Outside the window dvi_d=0.
